tx_comma_gen: RTL and testbench

- Transmit-side 8b/10b symbol generator: encodes byte/K-flag input into 10-bit symbols and tracks running disparity (RD).
- Guarantees comma (K28.5) content on the line: an alignment preamble, idle fill, and forced periodic insertion.
- Sits before the serializer; its output is what the far-end receiver's comma detector locks onto.

---
 rtl/tx_comma_gen.sv | 184 ++++++++++++++++++
 tb/tb_tx_comma_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_comma_gen.sv
// rtl/tx_comma_gen.sv - 8b/10b transmit symbol generator with comma preamble, idle fill and forced comma insertion
//
// Purpose: encodes byte/K-flag input into 10-bit 8b/10b symbols, tracks running
// disparity, and guarantees K28.5 content on the line (alignment preamble,
// idle fill, and a forced comma after COMMA_PERIOD consecutive non-comma symbols).
//
// Ports:
//   i_Clk      clock
//   i_Rst      synchronous active-high reset
//   i_Data     byte to encode, HGF_EDCBA
//   i_K        1 = control character
//   i_Valid    input byte valid
//   o_Ready    byte accepted this cycle when i_Valid && o_Ready
//   i_ReAlign  single-cycle pulse, re-enters the alignment preamble
//   o_Data     encoded symbol {a,b,c,d,e,i,f,g,h,j}, a at bit 9
//   o_Valid    o_Data holds a valid symbol
//   o_IsComma  o_Data is a K28.5
//   o_Rd       running disparity after o_Data (0 = RD-, 1 = RD+)
//   o_Err      one-cycle pulse: an invalid K code was replaced by K28.5
module tx_comma_gen #(
  parameter int          COMMA_PERIOD = 1024,
  parameter int          ALIGN_LEN    = 16,
  parameter logic [9:0]  PCOMMA       = 10'b0011111010,
  parameter logic [9:0]  MCOMMA       = 10'b1100000101
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Data,
  input  logic       i_K,
  input  logic       i_Valid,
  output logic       o_Ready,
  input  logic       i_ReAlign,
  output logic [9:0] o_Data,
  output logic       o_Valid,
  output logic       o_IsComma,
  output logic       o_Rd,
  output logic       o_Err
);

  typedef enum logic {ALIGN, DATA} stateType;

  localparam logic [15:0] periodMax = 16'(COMMA_PERIOD);
  localparam logic [7:0]  alignLast = 8'(ALIGN_LEN - 1);

  stateType    state, stateNext;
  logic [7:0]  alignCnt, alignCntNext;
  logic [15:0] cnt, cntNext;
  logic [9:0]  symNext;
  logic        rdNext, errNext, isCommaNext;

  logic        accept, kLegal, badK;
  logic [4:0]  x5;
  logic [2:0]  y3;
  logic [5:0]  raw6, code6;
  logic [3:0]  raw4, code4;
  logic        unb6, unb4, rd6, useA7;

  // 5b/6b table, RD- column (abcdei). The RD+ column is the complement for
  // unbalanced codes and for D.7; all other balanced codes are identical.
  function automatic logic [5:0] lut6(input logic [4:0] x);
    case (x)
      5'd0:  lut6 = 6'b100111;  5'd1:  lut6 = 6'b011101;
      5'd2:  lut6 = 6'b101101;  5'd3:  lut6 = 6'b110001;
      5'd4:  lut6 = 6'b110101;  5'd5:  lut6 = 6'b101001;
      5'd6:  lut6 = 6'b011001;  5'd7:  lut6 = 6'b111000;
      5'd8:  lut6 = 6'b111001;  5'd9:  lut6 = 6'b100101;
      5'd10: lut6 = 6'b010101;  5'd11: lut6 = 6'b110100;
      5'd12: lut6 = 6'b001101;  5'd13: lut6 = 6'b101100;
      5'd14: lut6 = 6'b011100;  5'd15: lut6 = 6'b010111;
      5'd16: lut6 = 6'b011011;  5'd17: lut6 = 6'b100011;
      5'd18: lut6 = 6'b010011;  5'd19: lut6 = 6'b110010;
      5'd20: lut6 = 6'b001011;  5'd21: lut6 = 6'b101010;
      5'd22: lut6 = 6'b011010;  5'd23: lut6 = 6'b111010;
      5'd24: lut6 = 6'b110011;  5'd25: lut6 = 6'b100110;
      5'd26: lut6 = 6'b010110;  5'd27: lut6 = 6'b110110;
      5'd28: lut6 = 6'b001110;  5'd29: lut6 = 6'b101110;
      5'd30: lut6 = 6'b011110;  default: lut6 = 6'b101011;
    endcase
  endfunction

  // 3b/4b table, RD- column (fghj). Control characters use their own column;
  // every K sub-block and D.x.3 is complemented at RD+ even when balanced.
  function automatic logic [3:0] lut4(input logic [2:0] y, input logic k, input logic a7);
    if (k) begin
      case (y)
        3'd0: lut4 = 4'b1011;  3'd1: lut4 = 4'b0110;
        3'd2: lut4 = 4'b1010;  3'd3: lut4 = 4'b1100;
        3'd4: lut4 = 4'b1101;  3'd5: lut4 = 4'b0101;
        3'd6: lut4 = 4'b1001;  default: lut4 = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: lut4 = 4'b1011;  3'd1: lut4 = 4'b1001;
        3'd2: lut4 = 4'b0101;  3'd3: lut4 = 4'b1100;
        3'd4: lut4 = 4'b1101;  3'd5: lut4 = 4'b1010;
        3'd6: lut4 = 4'b0110;  default: lut4 = a7 ? 4'b0111 : 4'b1110;
      endcase
    end
  endfunction

  assign x5 = i_Data[4:0];
  assign y3 = i_Data[7:5];

  assign o_Ready = (state == DATA) && (cnt < periodMax) && !i_Rst && !i_ReAlign;
  assign accept  = i_Valid && o_Ready;

  assign kLegal = (x5 == 5'd28) ||
                  ((y3 == 3'd7) && ((x5 == 5'd23) || (x5 == 5'd27) ||
                                    (x5 == 5'd29) || (x5 == 5'd30)));
  assign badK   = i_K && !kLegal;

  // Encoder datapath, evaluated against the current running disparity.
  always_comb begin
    raw6  = (i_K && (x5 == 5'd28)) ? 6'b001111 : lut6(x5);
    unb6  = ($countones(raw6) != 3);
    code6 = (o_Rd && (unb6 || (!i_K && (x5 == 5'd7)))) ? ~raw6 : raw6;
    rd6   = o_Rd ^ unb6;
    // A7 avoids a run of five identical bits across the 6b/4b boundary.
    useA7 = !i_K && (y3 == 3'd7) &&
            (rd6 ? ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14))
                 : ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20)));
    raw4  = lut4(y3, i_K, useA7);
    unb4  = ($countones(raw4) != 2);
    code4 = (rd6 && (unb4 || (y3 == 3'd3) || i_K)) ? ~raw4 : raw4;
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateNext    = state;
    alignCntNext = alignCnt;
    symNext      = o_Rd ? MCOMMA : PCOMMA;
    rdNext       = ~o_Rd;
    errNext      = accept && badK;
    cntNext      = cnt;

    if (accept && !badK) begin
      symNext = {code6, code4};
      rdNext  = rd6 ^ unb4;
    end

    isCommaNext = (symNext == PCOMMA) || (symNext == MCOMMA);

    if (isCommaNext) begin
      cntNext = '0;
    end else if (cnt < periodMax) begin
      cntNext = cnt + 16'd1;
    end

    if (i_ReAlign) begin
      stateNext    = ALIGN;
      alignCntNext = '0;
    end else if (state == ALIGN) begin
      if (alignCnt == alignLast) begin
        stateNext    = DATA;
        alignCntNext = '0;
      end else begin
        alignCntNext = alignCnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ALIGN;
      alignCnt  <= '0;
      cnt       <= '0;
      o_Data    <= '0;
      o_Valid   <= 1'b0;
      o_IsComma <= 1'b0;
      o_Rd      <= 1'b0;
      o_Err     <= 1'b0;
    end else begin
      state     <= stateNext;
      alignCnt  <= alignCntNext;
      cnt       <= cntNext;
      o_Data    <= symNext;
      o_Valid   <= 1'b1;
      o_IsComma <= isCommaNext;
      o_Rd      <= rdNext;
      o_Err     <= errNext;
    end
  end

endmodule

// File: tb/tb_tx_comma_gen.sv
// tb/tb_tx_comma_gen.sv - self-checking bench for tx_comma_gen
module tb_tx_comma_gen;

  localparam int CP = 8;
  localparam int AL = 4;
  localparam logic [9:0] PC = 10'b0011111010;
  localparam logic [9:0] MC = 10'b1100000101;

  // Full 8b/10b code tables with both disparity columns written out.
  localparam logic [5:0] T6M [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] D4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4M [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                        8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic       i_Clk = 1'b0;
  logic       i_Rst, i_K, i_Valid, i_ReAlign;
  logic [7:0] i_Data;
  logic       o_Ready, o_Valid, o_IsComma, o_Rd, o_Err;
  logic [9:0] o_Data;

  always #5 i_Clk = ~i_Clk;

  tx_comma_gen #(.COMMA_PERIOD(CP), .ALIGN_LEN(AL), .PCOMMA(PC), .MCOMMA(MC)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .i_K(i_K), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .i_ReAlign(i_ReAlign), .o_Data(o_Data), .o_Valid(o_Valid),
    .o_IsComma(o_IsComma), .o_Rd(o_Rd), .o_Err(o_Err));

  int checks = 0;
  int failures = 0;

  // Reference model state: disparity, preamble commas still owed, run length.
  bit         mRd, mInData, lastAccept;
  int         mPreLeft, mRun;
  logic [9:0] eData;
  bit         eValid, eRd, eComma, eErr, eReady;
  logic       sampReady;

  typedef struct {
    bit rst; bit valid; logic [7:0] data; bit k; bit realign;
    bit eRdy; logic [9:0] eSym; bit eVal; bit eRdOut; bit eCom; bit eErrOut;
  } vecT;
  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit kLegal(input logic [7:0] d);
    for (int i = 0; i < 12; i++) if (KLIST[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] refEncode(input logic [7:0] d, input bit k);
    int x, y;
    logic [5:0] six;
    logic [3:0] four;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    if (k && x == 28) six = mRd ? 6'b110000 : 6'b001111;
    else six = mRd ? T6P[x] : T6M[x];
    if ($countones(six) != 3) mRd = !mRd;
    if (k) four = mRd ? K4P[y] : K4M[y];
    else if (y == 7 && ((!mRd && (x == 17 || x == 18 || x == 20)) ||
                        (mRd && (x == 11 || x == 13 || x == 14))))
      four = mRd ? 4'b1000 : 4'b0111;
    else four = mRd ? D4P[y] : D4M[y];
    if ($countones(four) != 2) mRd = !mRd;
    return {six, four};
  endfunction

  // Called just after a falling edge: drive inputs, check o_Ready, advance the
  // model across the next rising edge, then check the registered outputs.
  task automatic step(input bit rst, input bit valid, input logic [7:0] data, input bit k, input bit realign);
    bit err, com;
    logic [9:0] sym;
    i_Rst = rst; i_Valid = valid; i_Data = data; i_K = k; i_ReAlign = realign;
    #1;
    eReady = !rst && mInData && (mRun < CP) && !realign;
    sampReady = o_Ready;
    check("o_Ready", sampReady, eReady);
    lastAccept = 1'b0;
    if (rst) begin
      eData = '0; eValid = 0; eRd = 0; eComma = 0; eErr = 0;
      mRd = 0; mRun = 0; mInData = 0; mPreLeft = AL;
    end else begin
      lastAccept = valid && eReady;
      err = lastAccept && k && !kLegal(data);
      if (lastAccept && !err) begin
        sym = refEncode(data, k);
        com = k && (data == 8'hBC);
      end else begin
        sym = mRd ? MC : PC;
        mRd = !mRd;
        com = 1'b1;
      end
      mRun = com ? 0 : ((mRun < CP) ? mRun + 1 : CP);
      if (realign) begin
        mInData = 0; mPreLeft = AL;
      end else if (!mInData) begin
        mPreLeft--;
        if (mPreLeft == 0) mInData = 1;
      end
      eData = sym; eValid = 1; eRd = mRd; eComma = com; eErr = err;
    end
    @(posedge i_Clk);
    @(negedge i_Clk);
    check("o_Data", o_Data, eData);
    check("o_Valid", o_Valid, eValid);
    check("o_Rd", o_Rd, eRd);
    check("o_IsComma", o_IsComma, eComma);
    check("o_Err", o_Err, eErr);
  endtask

  initial begin
    logic [7:0] seq;
    int dataSyms;
    i_Rst = 1; i_Valid = 0; i_Data = '0; i_K = 0; i_ReAlign = 0;
    mRd = 0; mInData = 0; mPreLeft = AL; mRun = 0;

    // rst valid data k realign | ready symbol valid rd comma err
    vecs.push_back('{1, 1, 8'h00, 0, 0, 0, 10'b0000000000, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, PC,            1, 1, 1, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, MC,            1, 0, 1, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, PC,            1, 1, 1, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 0, MC,            1, 0, 1, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 1, 10'b1001110100, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 1, 10'b1001110100, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 1, 10'b1001110100, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, PC,            1, 1, 1, 0});
    vecs.push_back('{0, 1, 8'h00, 0, 0, 1, 10'b0110001011, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h00, 1, 0, 1, MC,            1, 0, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, PC,            1, 1, 1, 0});
    vecs.push_back('{0, 1, 8'h1C, 1, 0, 1, 10'b1100001011, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 8'hBC, 1, 0, 1, MC,            1, 0, 1, 0});

    @(negedge i_Clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].k, vecs[i].realign);
      check($sformatf("vec%0d_ready", i), sampReady, vecs[i].eRdy);
      check($sformatf("vec%0d_data", i), o_Data, vecs[i].eSym);
      check($sformatf("vec%0d_valid", i), o_Valid, vecs[i].eVal);
      check($sformatf("vec%0d_rd", i), o_Rd, vecs[i].eRdOut);
      check($sformatf("vec%0d_comma", i), o_IsComma, vecs[i].eCom);
      check($sformatf("vec%0d_err", i), o_Err, vecs[i].eErrOut);
    end

    // Forced insertion: eight data symbols then one comma, repeating every nine.
    seq = 8'h00;
    dataSyms = 0;
    for (int i = 0; i < 27; i++) begin
      step(0, 1, seq, 0, 0);
      check("period_comma", o_IsComma, (i % 9 == 8));
      if (!o_IsComma) dataSyms++;
      if (lastAccept) seq++;
    end
    check("period_data_count", dataSyms, 24);

    // Re-align mid-stream: ready drops at once, preamble follows, RD continues.
    step(0, 1, seq, 0, 1);
    check("realign_ready", sampReady, 0);
    check("realign_comma", o_IsComma, 1);
    for (int j = 0; j < AL; j++) begin
      step(0, 1, seq, 0, 0);
      check("align_ready", sampReady, 0);
      check("align_comma", o_IsComma, 1);
    end
    step(0, 1, seq, 0, 0);
    check("ready_after_align", sampReady, 1);
    if (lastAccept) seq++;

    // Reset in the middle of a preamble.
    step(0, 1, seq, 0, 1);
    step(0, 1, seq, 0, 0);
    step(0, 1, seq, 0, 0);
    step(1, 1, seq, 0, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_data", o_Data, 0);
    step(0, 1, seq, 0, 0);
    check("post_rst_first", o_Data, PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit v, k, ra, r;
      logic [7:0] d;
      v  = ($urandom_range(3) != 0);
      k  = ($urandom_range(7) == 0);
      d  = 8'($urandom);
      if (k && $urandom_range(1) == 1) d = KLIST[$urandom_range(11)];
      ra = ($urandom_range(199) == 0);
      r  = ($urandom_range(499) == 0);
      step(r, v, d, k, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
